mod_n_counter: RTL and testbench
================================

# mod_n_counter

Parametrised synchronous modulo-N counter. It is the next generation of the team's T-flip-flop ripple counters: one clock domain, a decoded modulus instead of a glitch-prone asynchronous feedback reset, a synchronous load and preset, and a carry output for cascading. It sits in the sequential-logic library as the standard count/divide primitive that benches and later datapath blocks instantiate.

## Interface
- WIDTH, 5: counter width in bits.
- MODULUS, 9: count range is 0 .. MODULUS-1. Elaboration error unless 2 <= MODULUS <= 2**WIDTH.
- clock  input  1  sole clock; all state changes on its rising edge.
- clear  input  1  asynchronous, active-low reset.
- enable  input  1  count one step this cycle.
- preset  input  1  synchronous; load MODULUS-1.
- load  input  1  synchronous; load load_value.
- load_value  input  WIDTH  value for load.
- up  input  1  direction, 1 = up, 0 = down. Present only with the direction macro.
- count  output  WIDTH  registered count value.
- tc  output  1  terminal count, combinational from count and direction.
- carry_out  output  1  tc & enable, combinational; drives the next stage's enable.
- wrap  output  1  registered one-cycle pulse after a wrap.
- load_err  output  1  registered one-cycle pulse after a rejected load.

## Operation
- Reset values while clear=0: count=0, wrap=0, load_err=0.
- Per-edge priority: preset > load > enable > hold.
- Preset: count <= MODULUS-1; wrap <= 0; load_err <= 0.
- Load with load_value < MODULUS: count <= load_value.
- Load with load_value >= MODULUS: count holds; load_err <= 1 for exactly one cycle. Enable is ignored in that cycle.
- Enable, counting up: count <= (count == MODULUS-1) ? 0 : count+1.
- Enable, counting down: count <= (count == 0) ? MODULUS-1 : count-1.
- wrap <= 1 only in a cycle where enable performs a terminal-to-start transition. Otherwise wrap <= 0.
- tc = (count == MODULUS-1) when counting up; tc = (count == 0) when counting down.
- count never holds a value >= MODULUS. No intermediate illegal states are ever visible.
- Arithmetic is done at WIDTH+1 bits internally, so MODULUS = 2**WIDTH wraps correctly.

## Timing
- Single-cycle latency: an input sampled at edge k is reflected in count after edge k.
- tc and carry_out follow count, direction and enable combinationally in the same cycle.
- wrap and load_err are high during the cycle after the triggering edge only.
- Clear assertion forces all registers to reset values immediately, without waiting for a clock edge.
- Clear deassertion takes effect at the first rising edge that follows it.
- Clear mid-count discards any pending preset, load or count.
- If direction changes while count is at the terminal value, tc re-decodes immediately and the next enable follows the new direction.

## Configuration
- MOD_N_COUNTER_UPDOWN_EN defined: the up port exists and down-counting is supported as described above.
- MOD_N_COUNTER_UPDOWN_EN undefined: no up port. The counter is up-only and tc = (count == MODULUS-1).

## Structure
- Package mod_counter_pkg holds:
  - default constants DEF_WIDTH=5 and DEF_MODULUS=9;
  - enum dir_t {DIR_DOWN, DIR_UP};
  - a function that returns next count from (count, dir, MODULUS) and flags wrap.
- One combinational sub-module, mod_n_counter_next, computes next count, wrap and load validity. mod_n_counter holds only the registers and the priority mux.

## Test plan
1. WIDTH=5, MODULUS=9. Hold clear=0 for 2 cycles, then enable=1 for 12 cycles -> count goes 0,1..8,0,1,2,3. carry_out is high only while count=8. wrap pulses once, in the cycle count=0 first appears.
2. enable=0 for 5 cycles at count=4 -> count stays 4. tc=0, wrap=0.
3. load=1, load_value=5 -> count=5 next cycle. Then load_value=12 -> count stays 5 and load_err=1 for one cycle.
4. preset=1 and load=1 with load_value=2 in the same cycle -> count=8 and tc=1 when counting up.
5. With MOD_N_COUNTER_UPDOWN_EN, up=0, from count=0 with enable=1 -> count goes 8,7,6. wrap pulses after 0->8. tc=1 at count=0.
6. Pull clear low between edges while count=6 and enable=1 -> count=0 immediately, wrap=0, load_err=0. Counting resumes 1,2 after the first edge once clear is released.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Purpose : shared constants, direction type and next-count helper for mod_n_counter.
// Latency : n/a (types and a pure combinational function only).
// Backpr. : n/a.
// Contents: DEF_WIDTH/DEF_MODULUS defaults, dir_t, cnt_ext_t, next_count().
package mod_counter_pkg;

  localparam int unsigned DEF_WIDTH   = 5;
  localparam int unsigned DEF_MODULUS = 9;

  // Wide enough for any supported WIDTH plus one guard bit, so that
  // MODULUS = 2**WIDTH is representable and wraps cleanly.
  localparam int unsigned CNT_EXT_W = 33;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  typedef logic [CNT_EXT_W-1:0] cnt_ext_t;

  // Next value of a modulo counter stepping once in direction dir.
  // wrapped is set when the step moves from the terminal value to the start value.
  function automatic cnt_ext_t next_count(input  cnt_ext_t cnt,
                                          input  dir_t     dir,
                                          input  cnt_ext_t modulus,
                                          output logic     wrapped);
    cnt_ext_t last;
    cnt_ext_t nxt;
    last    = modulus - cnt_ext_t'(1);
    wrapped = 1'b0;
    if (dir == DIR_UP) begin
      if (cnt == last) begin
        nxt     = '0;
        wrapped = 1'b1;
      end else begin
        nxt = cnt + cnt_ext_t'(1);
      end
    end else begin
      if (cnt == '0) begin
        nxt     = last;
        wrapped = 1'b1;
      end else begin
        nxt = cnt - cnt_ext_t'(1);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mod_n_counter_next.sv
// Purpose : combinational next-count, wrap flag, load-value check and terminal-count decode.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the owner of the registers decides whether to use the results.
// Ports   : count_i, dir_i, load_value_i -> next_o, wrap_o, load_ok_o, tc_o.
module mod_n_counter_next
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic [WIDTH-1:0] count_i,
  input  dir_t             dir_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o,
  output logic             load_ok_o,
  output logic             tc_o
);

  // Comparisons use one extra bit so MODULUS = 2**WIDTH does not alias to 0.
  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] LAST_EXT = MOD_EXT - 1'b1;

  always_comb begin
    wrap_o = 1'b0;
    next_o = WIDTH'(next_count(cnt_ext_t'(count_i), dir_i, cnt_ext_t'(MODULUS), wrap_o));
  end

  assign load_ok_o = ({1'b0, load_value_i} < MOD_EXT);

  assign tc_o = (dir_i == DIR_UP) ? ({1'b0, count_i} == LAST_EXT) : (count_i == '0);

endmodule

// File: rtl/mod_n_counter.sv
// Purpose : synchronous modulo-MODULUS counter with preset, checked load and carry for cascading.
// Latency : 1 cycle from sampled control to count/wrap/load_err; tc and carry_out are combinational.
// Backpr. : none; enable is accepted every cycle, carry_out feeds the next stage's enable.
// Ports   : clock, clear (async active-low), enable, preset, load, load_value, [up]
//           -> count, tc, carry_out, wrap, load_err.
// Config  : define MOD_N_COUNTER_UPDOWN_EN to add the up port and down-counting.
module mod_n_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef MOD_N_COUNTER_UPDOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry_out,
  output logic             wrap,
  output logic             load_err
);

  if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
    $error("mod_n_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  dir_t             dir;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic             load_ok;

`ifdef MOD_N_COUNTER_UPDOWN_EN
  assign dir = up ? DIR_UP : DIR_DOWN;
`else
  assign dir = DIR_UP;
`endif

  mod_n_counter_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .count_i     (count_q),
    .dir_i       (dir),
    .load_value_i(load_value),
    .next_o      (step_val),
    .wrap_o      (step_wrap),
    .load_ok_o   (load_ok),
    .tc_o        (tc)
  );

  // Priority: preset > load > enable > hold. A rejected load still owns the
  // cycle, so enable is ignored and the count holds.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (preset) begin
      count_d = LAST;
    end else if (load) begin
      if (load_ok) begin
        count_d = load_value;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (enable) begin
      count_d = step_val;
      wrap_d  = step_wrap;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count     = count_q;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;
  assign carry_out = tc & enable;

endmodule

// File: tb/tb_mod_n_counter.sv
// Purpose : directed self-checking bench for mod_n_counter (WIDTH=5, MODULUS=9).
// Latency : expected values are queued when a step is driven and popped one edge later.
// Backpr. : n/a.
module tb_mod_n_counter;

  localparam int W = 5;
  localparam int M = 9;

  logic         clock = 1'b0;
  logic         clear;
  logic         enable;
  logic         preset;
  logic         load;
  logic [W-1:0] load_value;
`ifdef MOD_N_COUNTER_UPDOWN_EN
  logic         up;
`endif
  logic [W-1:0] count;
  logic         tc;
  logic         carry_out;
  logic         wrap;
  logic         load_err;

  mod_n_counter #(
    .WIDTH  (W),
    .MODULUS(M)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .enable    (enable),
    .preset    (preset),
    .load      (load),
    .load_value(load_value),
`ifdef MOD_N_COUNTER_UPDOWN_EN
    .up        (up),
`endif
    .count     (count),
    .tc        (tc),
    .carry_out (carry_out),
    .wrap      (wrap),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         wrp;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state of the counter as the bench believes it to be.
  int   m_cnt  = 0;
  bit   m_up   = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of controls at a falling edge, check the combinational
  // outputs, queue the post-edge expectation, then compare it after the edge.
  task automatic step(input logic en, input logic pr, input logic ld,
                      input logic [W-1:0] lv, input string tag);
    exp_t e;
    exp_t got;
    bit   exp_tc;
    enable     = en;
    preset     = pr;
    load       = ld;
    load_value = lv;
    #1;
    exp_tc = m_up ? (m_cnt == M - 1) : (m_cnt == 0);
    check({tag, ".tc"}, tc, exp_tc);
    check({tag, ".carry"}, carry_out, exp_tc & en);

    e.wrp = 1'b0;
    e.err = 1'b0;
    if (pr) begin
      m_cnt = M - 1;
    end else if (ld) begin
      if (int'(lv) < M) m_cnt = int'(lv);
      else e.err = 1'b1;
    end else if (en) begin
      if (m_up) begin
        if (m_cnt == M - 1) begin m_cnt = 0; e.wrp = 1'b1; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin m_cnt = M - 1; e.wrp = 1'b1; end
        else m_cnt = m_cnt - 1;
      end
    end
    e.cnt = W'(m_cnt);
    sb_q.push_back(e);

    @(posedge clock);
    #1;
    got = sb_q.pop_front();
    check({tag, ".count"}, count, got.cnt);
    check({tag, ".wrap"}, wrap, got.wrp);
    check({tag, ".load_err"}, load_err, got.err);
    @(negedge clock);
  endtask

  initial begin
    int seq1 [12];
    int wraps;
    seq1 = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 2, 3};

    clear      = 1'b0;
    enable     = 1'b0;
    preset     = 1'b0;
    load       = 1'b0;
    load_value = '0;
`ifdef MOD_N_COUNTER_UPDOWN_EN
    up         = 1'b1;
`endif

    // Reset values, held across two edges.
    #1;
    check("rst.count", count, 0);
    check("rst.wrap", wrap, 0);
    check("rst.load_err", load_err, 0);
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hold.count", count, 0);
    @(negedge clock);
    clear = 1'b1;

    // 1: twelve enables, 0..8 then wraps to 0..3; wrap pulses exactly once.
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, "t1");
      check("t1.seq", count, seq1[i]);
      if (wrap) wraps++;
    end
    check("t1.wrap_once", wraps, 1);

    // 2: advance to 4, then hold for five cycles.
    step(1'b1, 1'b0, 1'b0, '0, "t2.adv");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, "t2.hold");
    end
    check("t2.count4", count, 4);
    check("t2.tc", tc, 0);

    // 3: legal load, then an out-of-range load with enable also high.
    step(1'b0, 1'b0, 1'b1, W'(5), "t3.load5");
    check("t3.count5", count, 5);
    step(1'b1, 1'b0, 1'b1, W'(12), "t3.load12");
    check("t3.held", count, 5);
    check("t3.err_pulse", load_err, 1);
    step(1'b0, 1'b0, 1'b0, '0, "t3.after");
    check("t3.err_gone", load_err, 0);

    // 4: preset beats a simultaneous load; then terminal -> start wrap.
    step(1'b0, 1'b1, 1'b1, W'(2), "t4.preset");
    check("t4.count8", count, 8);
    check("t4.tc_up", tc, 1);
    step(1'b1, 1'b0, 1'b0, '0, "t4.wrap");
    check("t4.count0", count, 0);
    check("t4.wrap_pulse", wrap, 1);

`ifdef MOD_N_COUNTER_UPDOWN_EN
    // 5: direction flips at count 0; tc re-decodes, then count down 8,7,6.
    up   = 1'b0;
    m_up = 1'b0;
    #1;
    check("t5.tc_redecode", tc, 1);
    step(1'b1, 1'b0, 1'b0, '0, "t5.d1");
    check("t5.count8", count, 8);
    check("t5.wrap", wrap, 1);
    step(1'b1, 1'b0, 1'b0, '0, "t5.d2");
    check("t5.count7", count, 7);
    step(1'b1, 1'b0, 1'b0, '0, "t5.d3");
    check("t5.count6", count, 6);
    up   = 1'b1;
    m_up = 1'b1;
`endif

    // 6: asynchronous clear mid-count, with a load_err pulse in flight.
    step(1'b0, 1'b0, 1'b1, W'(6), "t6.load6");
    step(1'b0, 1'b0, 1'b1, W'(20), "t6.badload");
    check("t6.err_before", load_err, 1);
    enable = 1'b1;
    load   = 1'b0;
    #2;
    clear = 1'b0;
    #1;
    check("t6.async_count", count, 0);
    check("t6.async_wrap", wrap, 0);
    check("t6.async_err", load_err, 0);
    m_cnt = 0;
    sb_q.delete();
    @(posedge clock);
    #1;
    check("t6.clear_held", count, 0);
    @(negedge clock);
    clear = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0, "t6.r1");
    check("t6.count1", count, 1);
    step(1'b1, 1'b0, 1'b0, '0, "t6.r2");
    check("t6.count2", count, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
